// File: rtl/conv_layer_strided.sv
// Strided KXxKYxICH -> OCH convolution with stride decimation and requantisation; 3-cycle latency.
// One window per cycle, no backpressure: non-kept windows flow through as bubbles.
module conv_layer_strided #(
  parameter int F      = 28,
  parameter int B      = 8,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int ICH    = 1,
  parameter int OCH    = 16,
  parameter int STRIDE = 2,
  parameter int SHIFT  = 6,
  parameter int RELU   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [KX*KY*ICH*B-1:0]    i_pixel_data,
  input  logic                      i_pixel_data_valid,
  input  logic [OCH*KX*KY*ICH*B-1:0] i_weight,
  input  logic [OCH*B-1:0]          i_bias,
  output logic [OCH*B-1:0]          o_convolved_data,
  output logic                      o_convolved_valid,
  output logic                      o_frame_done
);

  localparam int N    = KX*KY*ICH;
  localparam int PW   = 2*B+1;
  localparam int ACCW = 2*B+1+$clog2(N)+1;
  localparam int CW   = (F > 1) ? $clog2(F) : 1;
  localparam int SW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OF   = (F+STRIDE-1)/STRIDE;

  localparam logic [CW-1:0] CMAX = CW'(F-1);
  localparam logic [CW-1:0] LAST = CW'((OF-1)*STRIDE);
  localparam logic [SW-1:0] SMAX = SW'(STRIDE-1);

  localparam logic signed [ACCW-1:0] HI = (RELU != 0) ? ACCW'(2**B-1)   : ACCW'(2**(B-1)-1);
  localparam logic signed [ACCW-1:0] LO = (RELU != 0) ? ACCW'(0)        : ACCW'(-(2**(B-1)));

  // Position counters plus stride-phase counters, so the keep test needs no modulo.
  logic [CW-1:0] col, row, ecol, erow;
  logic [SW-1:0] cph, rph, ecph, erph;
  logic          keep, last_beat;

  always_comb begin
    ecol      = i_start ? '0 : col;
    erow      = i_start ? '0 : row;
    ecph      = i_start ? '0 : cph;
    erph      = i_start ? '0 : rph;
    keep      = i_pixel_data_valid && (ecph == '0) && (erph == '0);
    last_beat = keep && (ecol == LAST) && (erow == LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
      cph <= '0;
      rph <= '0;
    end else if (i_pixel_data_valid) begin
      if (ecol == CMAX) begin
        col <= '0;
        cph <= '0;
        if (erow == CMAX) begin
          row <= '0;
          rph <= '0;
        end else begin
          row <= erow + 1'b1;
          rph <= (erph == SMAX) ? '0 : erph + 1'b1;
        end
      end else begin
        col <= ecol + 1'b1;
        cph <= (ecph == SMAX) ? '0 : ecph + 1'b1;
        row <= erow;
        rph <= erph;
      end
    end else if (i_start) begin
      col <= '0;
      row <= '0;
      cph <= '0;
      rph <= '0;
    end
  end

  logic signed [PW-1:0]   prod_c [OCH][N];
  logic signed [PW-1:0]   p1     [OCH][N];
  logic signed [ACCW-1:0] acc_c  [OCH];
  logic signed [ACCW-1:0] a2     [OCH];
  logic signed [ACCW-1:0] sh_c   [OCH];
  logic signed [ACCW-1:0] res_c  [OCH];
  logic [OCH*B-1:0]       data_c;
  logic                   v1, l1, v2, l2;

  // Pixels are unsigned: zero-extend before the signed multiply.
  always_comb begin
    prod_c = '{default: '0};
    for (int o = 0; o < OCH; o++) begin
      for (int i = 0; i < N; i++) begin
        prod_c[o][i] = $signed(PW'({1'b0, i_pixel_data[i*B +: B]}))
                     * PW'($signed(i_weight[(o*N+i)*B +: B]));
      end
    end
  end

  always_comb begin
    acc_c = '{default: '0};
    for (int o = 0; o < OCH; o++) begin
      acc_c[o] = ACCW'($signed(i_bias[o*B +: B])) <<< SHIFT;
      for (int i = 0; i < N; i++) begin
        acc_c[o] = acc_c[o] + ACCW'(p1[o][i]);
      end
    end
  end

  always_comb begin
    sh_c   = '{default: '0};
    res_c  = '{default: '0};
    data_c = '0;
    for (int o = 0; o < OCH; o++) begin
      sh_c[o] = a2[o] >>> SHIFT;
      if (sh_c[o] < LO)
        res_c[o] = LO;
      else if (sh_c[o] > HI)
        res_c[o] = HI;
      else
        res_c[o] = sh_c[o];
      data_c[o*B +: B] = B'(res_c[o]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p1                <= '{default: '0};
      a2                <= '{default: '0};
      v1                <= 1'b0;
      l1                <= 1'b0;
      v2                <= 1'b0;
      l2                <= 1'b0;
      o_convolved_data  <= '0;
      o_convolved_valid <= 1'b0;
      o_frame_done      <= 1'b0;
    end else begin
      p1                <= prod_c;
      v1                <= keep;
      l1                <= last_beat;
      a2                <= acc_c;
      v2                <= v1;
      l2                <= l1;
      o_convolved_valid <= v2;
      o_frame_done      <= v2 && l2;
      if (v2)
        o_convolved_data <= data_c;
    end
  end

endmodule

// File: tb/tb_conv_layer_strided.sv
// Bench for conv_layer_strided: window-level arithmetic model plus directed literal expectations.
module tb_conv_layer_strided;

  localparam int F = 28, B = 8, KX = 3, KY = 3, ICH = 1, OCH = 16, STRIDE = 2, SHIFT = 6;
  localparam int N  = KX*KY*ICH;
  localparam int OF = (F+STRIDE-1)/STRIDE;
  localparam int LK = (OF-1)*STRIDE;
  localparam int DW = OCH*B;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
  logic [N*B-1:0]     pixel_data;
  logic [OCH*N*B-1:0] weight;
  logic [OCH*B-1:0]   bias;
  logic [DW-1:0]      data1, data0;
  logic               valid1, valid0, fd1, fd0;

  conv_layer_strided #(.F(F), .B(B), .KX(KX), .KY(KY), .ICH(ICH), .OCH(OCH),
                       .STRIDE(STRIDE), .SHIFT(SHIFT), .RELU(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pixel_data(pixel_data),
    .i_pixel_data_valid(valid), .i_weight(weight), .i_bias(bias),
    .o_convolved_data(data1), .o_convolved_valid(valid1), .o_frame_done(fd1));

  conv_layer_strided #(.F(F), .B(B), .KX(KX), .KY(KY), .ICH(ICH), .OCH(OCH),
                       .STRIDE(STRIDE), .SHIFT(SHIFT), .RELU(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pixel_data(pixel_data),
    .i_pixel_data_valid(valid), .i_weight(weight), .i_bias(bias),
    .o_convolved_data(data0), .o_convolved_valid(valid0), .o_frame_done(fd0));

  always #5 clk = ~clk;

  int pix [N];
  int w   [OCH][N];
  int bs  [OCH];

  always_comb begin
    pixel_data = '0;
    weight     = '0;
    bias       = '0;
    for (int i = 0; i < N; i++) pixel_data[i*B +: B] = pix[i][B-1:0];
    for (int o = 0; o < OCH; o++) begin
      bias[o*B +: B] = bs[o][B-1:0];
      for (int i = 0; i < N; i++) weight[(o*N+i)*B +: B] = w[o][i][B-1:0];
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] d1;
    logic [DW-1:0] d0;
    bit            fd;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0, total = 0, bad = 0;
  int            idx = 0, kept_cnt = 0, out_cnt = 0, fd_cnt = 0, fd_at = 0;
  bit            run = 0;
  logic [DW-1:0] hold1 = '0, hold0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Window-level reference: full-precision sum, floor shift, clamp.
  function automatic logic [DW-1:0] model_out(input int relu);
    logic [DW-1:0] r;
    int acc, v;
    r = '0;
    for (int o = 0; o < OCH; o++) begin
      acc = bs[o] * (2**SHIFT);
      for (int i = 0; i < N; i++) acc += pix[i] * w[o][i];
      v = acc >>> SHIFT;
      if (relu != 0) begin
        if (v < 0) v = 0;
        if (v > 2**B-1) v = 2**B-1;
      end else begin
        if (v < -(2**(B-1))) v = -(2**(B-1));
        if (v > 2**(B-1)-1) v = 2**(B-1)-1;
      end
      r[o*B +: B] = v[B-1:0];
    end
    return r;
  endfunction

  task automatic beat(input bit st);
    exp_t e;
    int col, row;
    start = st;
    valid = 1'b1;
    if (st) idx = 0;
    col = idx % F;
    row = idx / F;
    if ((col % STRIDE == 0) && (row % STRIDE == 0)) begin
      e.due = cyc + 3;
      e.d1  = model_out(1);
      e.d0  = model_out(0);
      e.fd  = (row == LK) && (col == LK);
      q.push_back(e);
      kept_cnt++;
    end
    idx = (idx + 1) % (F*F);
    @(posedge clk); #1;
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic start_only();
    start = 1'b1;
    idx   = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic set_all(input int pv, input int wv, input int bv);
    for (int i = 0; i < N; i++) pix[i] = pv;
    for (int o = 0; o < OCH; o++) begin
      bs[o] = bv;
      for (int i = 0; i < N; i++) w[o][i] = wv;
    end
  endtask

  function automatic logic [DW-1:0] ch(input logic [DW-1:0] d, input int o);
    return DW'(d[o*B +: B]);
  endfunction

  // Cycle-by-cycle comparison against the model queue; data must hold between outputs.
  exp_t ce;
  bit   cexpv, cefd;
  always @(negedge clk) begin
    if (!rst && run) begin
      cexpv = (q.size() > 0) && (q[0].due == cyc);
      cefd  = 1'b0;
      if (cexpv) begin
        ce    = q.pop_front();
        hold1 = ce.d1;
        hold0 = ce.d0;
        cefd  = ce.fd;
      end
      chk("valid_relu", DW'(valid1), DW'(cexpv));
      chk("valid_sgn",  DW'(valid0), DW'(cexpv));
      chk("data_relu",  data1, hold1);
      chk("data_sgn",   data0, hold0);
      chk("fdone_relu", DW'(fd1), DW'(cefd));
      chk("fdone_sgn",  DW'(fd0), DW'(cefd));
      if (valid1) out_cnt++;
      if (fd1) begin fd_cnt++; fd_at = out_cnt; end
    end
  end

  initial begin
    int base_out, base_fd, base_kept, gap;
    set_all(0, 0, 0);
    idle(3);
    chk("reset_data", data1, '0);
    chk("reset_valid", DW'({valid1, valid0, fd1, fd0}), '0);
    rst = 1'b0;
    idle(2);
    run = 1'b1;

    // All ones, unity weights: sum of 9 pixels, checked cycle by cycle for latency.
    set_all(1, 64, 0);
    beat(1);
    chk("lat_c1", DW'(valid1), '0);
    idle(1);
    chk("lat_c2", DW'(valid1), '0);
    idle(1);
    chk("lat_c3", DW'(valid1), DW'(1));
    chk("ones_ch0", ch(data1, 0), DW'(9));
    chk("ones_ch15", ch(data1, 15), DW'(9));
    chk("ones_sgn_ch7", ch(data0, 7), DW'(9));
    idle(3);

    set_all(255, 127, 0);
    idle(2);
    beat(1); idle(3);
    chk("satp_relu", ch(data1, 3), DW'(8'hFF));
    chk("satp_sgn", ch(data0, 3), DW'(8'h7F));

    set_all(255, -128, 0);
    idle(2);
    beat(1); idle(3);
    chk("satn_relu", ch(data1, 12), DW'(8'h00));
    chk("satn_sgn", ch(data0, 12), DW'(8'h80));

    // -64 from bias, -1 from one tap: -65 >>> 6 floors to -2.
    set_all(1, 0, -1);
    for (int o = 0; o < OCH; o++) w[o][0] = -1;
    idle(2);
    beat(1); idle(3);
    chk("floor_sgn", ch(data0, 5), DW'(8'hFE));
    chk("floor_relu", ch(data1, 5), DW'(8'h00));

    set_all(200, 0, 3);
    idle(2);
    beat(1); idle(3);
    chk("bias_relu", ch(data1, 9), DW'(3));
    chk("bias_sgn", ch(data0, 9), DW'(3));

    // Full frame of back-to-back beats with channel-dependent weights.
    for (int o = 0; o < OCH; o++) begin
      bs[o] = o*3 - 20;
      for (int i = 0; i < N; i++) w[o][i] = ((o*5 + i*3) % 17) - 8;
    end
    idle(2);
    base_out = out_cnt;
    base_fd  = fd_cnt;
    for (int k = 0; k < F*F; k++) begin
      for (int i = 0; i < N; i++) pix[i] = (k*7 + i*13 + k/F) % 256;
      beat(k == 0);
    end
    idle(5);
    chk("frame_outputs", DW'(out_cnt - base_out), DW'(196));
    chk("frame_done_cnt", DW'(fd_cnt - base_fd), DW'(1));
    chk("frame_done_at", DW'(fd_at - base_out), DW'(196));

    // Gapped beats with a restart after 100 beats.
    base_out  = out_cnt;
    base_kept = kept_cnt;
    start_only();
    for (int k = 0; k < 300; k++) begin
      gap = (k >= 96 && k <= 100) ? 0 : $urandom_range(0, 2);
      idle(gap);
      for (int i = 0; i < N; i++) pix[i] = (k*11 + i*29) % 256;
      beat(k == 100);
    end
    idle(5);
    chk("gap_outputs", DW'(out_cnt - base_out), DW'(kept_cnt - base_kept));

    // Reset with two kept windows in flight.
    set_all(10, 64, 0);
    idle(2);
    beat(1);
    beat(1);
    rst = 1'b1;
    #1;
    chk("arst_data", data1 | data0, '0);
    chk("arst_valid", DW'({valid1, valid0, fd1, fd0}), '0);
    q.delete();
    hold1 = '0;
    hold0 = '0;
    idx   = 0;
    idle(2);
    rst = 1'b0;
    base_out = out_cnt;
    idle(8);
    chk("arst_no_valid", DW'(out_cnt - base_out), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
